// File: rtl/ifft8_seq.sv
// ifft8_seq: sequential 8-point inverse FFT (radix-2 decimation-in-frequency).
// Eight complex samples are loaded in natural order and transformed in place
// with one butterfly per clock. The results are then streamed out in natural
// order, read from bit-reversed buffer addresses.
`timescale 1ns/1ps
module ifft8_seq #(
    parameter int width   = 8,
    parameter int decimal = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] in_r,
    input  logic [width-1:0] in_i,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [width-1:0] out_r,
    output logic [width-1:0] out_i,
    output logic [2:0]       out_idx,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_UNLOAD  = 2'd2
    } state_t;

    // Twiddle constants W^m = e^{+j2*pi*m/8} in Q(width-decimal).decimal.
    // cos45 is rounded to nearest: 46341/65536 ~ 0.7071068.
    localparam int ONE_I  = 32'sd1 <<< decimal;
    localparam int C45_I  = (ONE_I * 32'sd46341 + 32'sd32768) >>> 16;
    localparam int NC45_I = 32'sd0 - C45_I;
    localparam logic [width-1:0] W_ONE  = ONE_I[width-1:0];
    localparam logic [width-1:0] W_C45  = C45_I[width-1:0];
    localparam logic [width-1:0] W_NC45 = NC45_I[width-1:0];
    localparam logic [width-1:0] W_ZERO = {width{1'b0}};

    // Fixed-point product: full 2*width precision, shift by decimal, wrap to width.
    function automatic logic [width-1:0] mul_q(input logic [width-1:0] x,
                                               input logic [width-1:0] y);
        logic signed [2*width-1:0] p;
        logic signed [2*width-1:0] s;
        p = $signed({{width{x[width-1]}}, x}) * $signed({{width{y[width-1]}}, y});
        s = p >>> decimal;
        return s[width-1:0];
    endfunction

    // Reverse the three address bits.
    function automatic logic [2:0] bitrev3(input logic [2:0] a);
        return {a[0], a[1], a[2]};
    endfunction

    // State and control registers
    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_in_cnt;
    logic [3:0]       r_bf_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [width-1:0] r_out_r;
    logic [width-1:0] r_out_i;
    logic [2:0]       r_out_idx;

    // In-place complex sample buffer
    logic [width-1:0] r_buf_re [0:7];
    logic [width-1:0] r_buf_im [0:7];

    // Handshake decode
    logic w_in_acc;
    logic w_out_acc;
    logic w_bf_last;
    logic w_out_last;

    // Butterfly datapath
    logic [1:0]       w_j;
    logic [2:0]       w_addr_a;
    logic [2:0]       w_addr_b;
    logic [1:0]       w_tw_m;
    logic [width-1:0] w_tw_re;
    logic [width-1:0] w_tw_im;
    logic [width-1:0] w_a_re;
    logic [width-1:0] w_a_im;
    logic [width-1:0] w_b_re;
    logic [width-1:0] w_b_im;
    logic [width:0]   w_sum_re;
    logic [width:0]   w_sum_im;
    logic [width:0]   w_dif_re;
    logic [width:0]   w_dif_im;
    logic [width-1:0] w_up_re;
    logic [width-1:0] w_up_im;
    logic [width-1:0] w_dh_re;
    logic [width-1:0] w_dh_im;
    logic [width-1:0] w_lo_re;
    logic [width-1:0] w_lo_im;

    // Unload read path
    logic [2:0] w_nxt_idx;
    logic [2:0] w_rd_addr;

    assign w_in_acc   = in_valid & r_in_ready;
    assign w_out_acc  = r_out_valid & out_ready;
    assign w_bf_last  = (r_state == ST_COMPUTE) && (r_bf_cnt == 4'd11);
    assign w_out_last = w_out_acc && (r_out_idx == 3'd7);

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_r     = r_out_r;
    assign out_i     = r_out_i;
    assign out_idx   = r_out_idx;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_in_acc && (r_in_cnt == 3'd7)) begin
                    w_state_nxt = ST_COMPUTE;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_COMPUTE: begin
                if (w_bf_last) begin
                    w_state_nxt = ST_UNLOAD;
                end else begin
                    w_state_nxt = ST_COMPUTE;
                end
            end
            ST_UNLOAD: begin
                if (w_out_last) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_UNLOAD;
                end
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    // Input counter, butterfly counter and registered in_ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_cnt   <= 3'd0;
            r_bf_cnt   <= 4'd0;
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= (w_state_nxt == ST_LOAD);
            if (w_in_acc) begin
                r_in_cnt <= r_in_cnt + 3'd1;
            end
            if (r_state == ST_COMPUTE) begin
                r_bf_cnt <= w_bf_last ? 4'd0 : (r_bf_cnt + 4'd1);
            end
        end
    end

    // Butterfly pair addresses and twiddle index for the current step.
    // Stage s pairs addresses 4>>s apart; twiddle exponent is (j mod span) << s.
    always_comb begin
        w_j      = r_bf_cnt[1:0];
        w_addr_a = 3'd0;
        w_addr_b = 3'd0;
        w_tw_m   = 2'd0;
        case (r_bf_cnt[3:2])
            2'd0: begin
                w_addr_a = {1'b0, w_j};
                w_addr_b = {1'b1, w_j};
                w_tw_m   = w_j;
            end
            2'd1: begin
                w_addr_a = {w_j[1], 1'b0, w_j[0]};
                w_addr_b = {w_j[1], 1'b1, w_j[0]};
                w_tw_m   = {w_j[0], 1'b0};
            end
            2'd2: begin
                w_addr_a = {w_j, 1'b0};
                w_addr_b = {w_j, 1'b1};
                w_tw_m   = 2'd0;
            end
            default: begin
                w_addr_a = 3'd0;
                w_addr_b = 3'd0;
                w_tw_m   = 2'd0;
            end
        endcase
    end

    // Twiddle lookup
    always_comb begin
        w_tw_re = W_ONE;
        w_tw_im = W_ZERO;
        case (w_tw_m)
            2'd0: begin
                w_tw_re = W_ONE;
                w_tw_im = W_ZERO;
            end
            2'd1: begin
                w_tw_re = W_C45;
                w_tw_im = W_C45;
            end
            2'd2: begin
                w_tw_re = W_ZERO;
                w_tw_im = W_ONE;
            end
            2'd3: begin
                w_tw_re = W_NC45;
                w_tw_im = W_C45;
            end
            default: begin
                w_tw_re = W_ONE;
                w_tw_im = W_ZERO;
            end
        endcase
    end

    // Butterfly arithmetic: halve sum and difference in width+1 bits, then twiddle the difference
    always_comb begin
        w_a_re   = r_buf_re[w_addr_a];
        w_a_im   = r_buf_im[w_addr_a];
        w_b_re   = r_buf_re[w_addr_b];
        w_b_im   = r_buf_im[w_addr_b];
        w_sum_re = {w_a_re[width-1], w_a_re} + {w_b_re[width-1], w_b_re};
        w_sum_im = {w_a_im[width-1], w_a_im} + {w_b_im[width-1], w_b_im};
        w_dif_re = {w_a_re[width-1], w_a_re} - {w_b_re[width-1], w_b_re};
        w_dif_im = {w_a_im[width-1], w_a_im} - {w_b_im[width-1], w_b_im};
        w_up_re  = w_sum_re[width:1];
        w_up_im  = w_sum_im[width:1];
        w_dh_re  = w_dif_re[width:1];
        w_dh_im  = w_dif_im[width:1];
        w_lo_re  = mul_q(w_dh_re, w_tw_re) - mul_q(w_dh_im, w_tw_im);
        w_lo_im  = mul_q(w_dh_re, w_tw_im) + mul_q(w_dh_im, w_tw_re);
    end

    // Sample buffer: written by accepted inputs in LOAD and by butterflies in COMPUTE
    always_ff @(posedge clk) begin
        if (w_in_acc) begin
            r_buf_re[r_in_cnt] <= in_r;
            r_buf_im[r_in_cnt] <= in_i;
        end else if (r_state == ST_COMPUTE) begin
            r_buf_re[w_addr_a] <= w_up_re;
            r_buf_im[w_addr_a] <= w_up_im;
            r_buf_re[w_addr_b] <= w_lo_re;
            r_buf_im[w_addr_b] <= w_lo_im;
        end
    end

    // Unload read address: current index before the first output, next index after
    always_comb begin
        w_nxt_idx = r_out_idx + 3'd1;
        if (r_out_valid) begin
            w_rd_addr = bitrev3(w_nxt_idx);
        end else begin
            w_rd_addr = bitrev3(r_out_idx);
        end
    end

    // Output register: presents x[n] in natural order, holding while stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_r     <= {width{1'b0}};
            r_out_i     <= {width{1'b0}};
            r_out_idx   <= 3'd0;
        end else if (r_state == ST_UNLOAD) begin
            if (!r_out_valid) begin
                r_out_valid <= 1'b1;
                r_out_r     <= r_buf_re[w_rd_addr];
                r_out_i     <= r_buf_im[w_rd_addr];
            end else if (out_ready) begin
                if (r_out_idx == 3'd7) begin
                    r_out_valid <= 1'b0;
                    r_out_idx   <= 3'd0;
                end else begin
                    r_out_idx <= w_nxt_idx;
                    r_out_r   <= r_buf_re[w_rd_addr];
                    r_out_i   <= r_buf_im[w_rd_addr];
                end
            end
        end
    end

endmodule
